// File: rtl/serial_add_pkg.sv
// Shared types and elaboration helpers for the serial 2-bit-per-beat adder.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 2;

  // Beat counter width: $clog2(N), never narrower than one bit.
  function automatic int cnt_width(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= SLICE_W) && ((w % SLICE_W) == 0);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_add2_slice.sv
// Combinational 2-bit ripple adder made of two full-adder stages.
module add2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       ci,
  output logic [2:0] r
);

  logic c1;

  assign r[0] = x[0] ^ y[0] ^ ci;
  assign c1   = (x[0] & y[0]) | (x[0] & ci) | (y[0] & ci);
  assign r[1] = x[1] ^ y[1] ^ c1;
  assign r[2] = (x[1] & y[1]) | (x[1] & c1) | (y[1] & c1);

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle adder: one 2-bit slice reused for WIDTH/2 beats, carry held
// in a register between beats, start/done handshake toward the requester.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / 2;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("serial_add_ctrl: WIDTH must be even and >= 2");
  end

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [2:0]       r;
  logic [WIDTH-1:0] sum_nxt;

  add2_slice u_slice (
    .x  (opa[1:0]),
    .y  (opb[1:0]),
    .ci (carry),
    .r  (r)
  );

  // Each beat's pair enters at the top so the LSB pair ends up lowest.
  always_comb begin
    sum_nxt = sum >> 2;
    sum_nxt[WIDTH-1 -: 2] = r[1:0];
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= b;
      carry <= cin;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == RUN) begin
      opa   <= opa >> 2;
      opb   <= opb >> 2;
      carry <= r[2];
      cnt   <= cnt + 1'b1;
      sum   <= sum_nxt;
      if (cnt == LAST) cout <= r[2];
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [WIDTH:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Result monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        chk("result", {23'd0, cout, sum}, {23'd0, e});
      end
    end
    prev_done = rst_n && done;
  end

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Waits (bounded) for done; returns negedges counted.
  task automatic wait_done(output int k, output int nb);
    k  = 0;
    nb = 0;
    do begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (busy) nb++;
    end while (!done && k < 40);
    if (!done) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic do_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    int k, nb;
    logic [WIDTH:0] e;
    e = model(x, y, c);
    a = x; b = y; cin = c; start = 1'b1;
    exp_q.push_back(e);
    wait_done(k, nb);
    chk("latency", k, N + 1);
    chk("busy_cycles", nb, N);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_fall", {31'd0, done}, 32'd0);
    chk("hold", {23'd0, cout, sum}, {23'd0, e});
  endtask

  initial begin
    int k, nb, snap;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum",  {24'd0, sum},  32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_no_done", done_cnt, 0);

    do_add(8'h5A, 8'h33, 1'b0);
    chk("basic_sum", {24'd0, sum}, 32'h8D);
    do_add(8'hFF, 8'h01, 1'b0);
    chk("carry1_cout", {31'd0, cout}, 32'd1);
    do_add(8'hFF, 8'hFF, 1'b1);
    chk("carry2_sum", {24'd0, sum}, 32'hFF);
    do_add(8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      do_add(8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Start during busy must be ignored.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    snap = done_cnt;
    wait_done(k, nb);
    repeat (N + 4) @(negedge clk);
    chk("ignored_start_one_done", done_cnt - snap, 1);
    chk("ignored_start_sum", {24'd0, sum}, 32'h30);

    // Back-to-back with start held high.
    a = 8'h05; b = 8'h06; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h05, 8'h06, 1'b0));
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 40);
    if (!done) chk("timeout", 32'd1, 32'd0);
    a = 8'h01; b = 8'h02;
    exp_q.push_back(model(8'h01, 8'h02, 1'b0));
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 40);
    start = 1'b0;
    chk("b2b_spacing", k, N + 1);
    chk("b2b_sum", {23'd0, cout, sum}, 32'h003);
    repeat (N + 3) @(negedge clk);
    chk("b2b_stops", {31'd0, busy}, 32'd0);

    // Asynchronous reset after two beats.
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    exp_q.push_back(model(8'h12, 8'h34, 1'b1));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_sum",  {24'd0, sum},  32'd0);
    chk("mid_rst_cout", {31'd0, cout}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_add(8'h7F, 8'h01, 1'b0);
    chk("post_rst_sum", {23'd0, cout, sum}, 32'h080);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Multi-cycle adder controller. It adds two WIDTH-bit operands by reusing a single 2-bit ripple-carry adder slice for WIDTH/2 consecutive beats, with the carry held in a register between beats. It sits between a requester (start/done handshake) and the 2-bit adder datapath, and trades latency for area relative to a full-width ripple adder.

## Interface
- WIDTH, default 8: operand width. Must be even and ≥ 2. N = WIDTH/2 beats per add.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request an add. Sampled only when busy=0.
- a  in  WIDTH  operand A. Captured on accepted start.
- b  in  WIDTH  operand B. Captured on accepted start.
- cin  in  1  carry-in. Captured on accepted start.
- busy  out  1  add in progress. Start is ignored while busy=1.
- done  out  1  one-cycle pulse: sum/cout are valid.
- sum  out  WIDTH  result bits. Held until the next accepted start.
- cout  out  1  carry-out of the MSB. Held with sum.

## Operation
- FSM states:
  - IDLE: waits for start.
  - RUN: performs the beats.
  - DONE: outputs result.
- Transitions:
  - IDLE→RUN on start.
  - RUN→RUN while beat count < N−1.
  - RUN→DONE after beat N−1.
  - DONE→RUN if start is high, otherwise DONE→IDLE.
- Accept, on the start edge in IDLE or DONE:
  - a→opa, b→opb, cin→carry reg.
  - Beat counter cleared to 0.
  - sum and cout cleared to 0.
- Beat i, at each RUN edge:
  - The slice adds opa[1:0], opb[1:0] and carry, giving a 3-bit result r.
  - sum ← {r[1:0], sum[WIDTH-1:2]}, so the result enters from the top and shifts right.
  - carry ← r[2].
  - opa and opb shift right by 2.
  - The counter increments.
- After beat N−1, sum holds the full result, LSB pair lowest, and cout = carry.
- Arithmetic is unsigned modulo 2^WIDTH. {cout, sum} = a + b + cin exactly. There is no overflow flag.
- A start while busy=1 is ignored. Operand and cin changes during RUN have no effect.
- When reset is asserted at any time, including mid-RUN:
  - State goes to IDLE immediately.
  - All outputs go to 0.
  - Internal registers go to 0.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE.
- Start accepted at edge E0:
  - busy=1 from E0.
  - Beats occur on edges E1..EN.
  - After EN: done=1, busy=0.
  - done falls at E(N+1) unless a new add completes then (not possible for N ≥ 1).
- Latency: done is asserted N edges after the accepting edge. For WIDTH=8 that is 4 edges.
- Throughput: one add per N+1 cycles back-to-back. A start in the DONE cycle is accepted on the same edge that drops done.
- sum/cout:
  - Stable and valid from the DONE cycle until the next accepting edge.
  - Cleared to 0 on that edge.
  - Not meaningful during RUN (partial shift contents).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package serial_add_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Function for the beat-counter width, $clog2(N) with a minimum of 1.
  - WIDTH legality check (even, ≥ 2) as an elaboration-time assertion.
- Sub-module add2_slice:
  - Combinational 2-bit ripple adder built from two full-adder stages.
  - Inputs: x[1:0], y[1:0], ci.
  - Output: r[2:0] = x + y + ci.
  - The controller instantiates it once.
- The controller contains the FSM, operand shift registers, carry reg, beat counter and sum shift register.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst_n=0, then release → busy=0, done=0, sum=0x00, cout=0. No done appears without a start.
- Basic add: a=0x5A, b=0x33, cin=0, start for 1 cycle → busy high for 4 cycles, then done for exactly 1 cycle with sum=0x8D, cout=0. Result is held afterwards.
- Carry chain: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Ignored start: accept a=0x10, b=0x20, then pulse start with a=0xAA, b=0x55 during busy → the single done shows sum=0x30, cout=0. No second done follows.
- Back-to-back: hold start high continuously, with new operands a=0x01, b=0x02 presented in the DONE cycle → accepted on that edge. The next done shows sum=0x03, with N+1 cycles between done pulses.
- Reset mid-operation: assert rst_n=0 asynchronously after 2 beats → busy, done, sum and cout drop to 0 immediately, before the next clock edge. After release, a=0x7F, b=0x01 → sum=0x80, cout=0.
